// File: rtl/err_sched_pkg.sv
// Shared types, widths and the error-recovery correction for the multiplier scheduler.
// Combinational only; no latency or backpressure of its own.
// Imported by the scheduler, its interface and the arbiter.
package err_sched_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam int ERP_LSB = 20;
    localparam int ERP_MSB = 31;
    localparam int PROD_W  = 32;
    localparam int OP_W    = 16;
    localparam int ERP_W   = ERP_MSB - ERP_LSB + 1;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            recover;
    } op_t;

    // Each error bit of weight 2^k is re-added at 2^(k+1); the bit at 2^31 overflows and is dropped.
    function automatic logic [PROD_W-1:0] recover_p(input logic [PROD_W-1:0] p,
                                                    input logic [ERP_W-1:0]  erp);
        return p + {erp[ERP_W-2:0], {(ERP_LSB + 1){1'b0}}};
    endfunction

endpackage

// File: rtl/err_recovery_sched_if.sv
// Requester, core and result signals of the shared multiplier scheduler.
// Pure wiring; latency and backpressure are defined by the scheduler.
// slave = scheduler side, master = requesters/core stub/consumer side.
interface err_recovery_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    import err_sched_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OP_W-1:0] req_a;
    logic [NREQ*OP_W-1:0] req_b;
    logic [NREQ-1:0]      req_recover;
    logic [OP_W-1:0]      core_a;
    logic [OP_W-1:0]      core_b;
    logic [PROD_W-1:0]    core_p;
    logic [ERP_W-1:0]     core_erp;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDW-1:0]       out_id;
    logic [PROD_W-1:0]    out_p;
    logic                 out_err;
    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, req_recover, core_p, core_erp, out_ready,
        output req_ready, core_a, core_b, out_valid, out_id, out_p, out_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_recover, core_p, core_erp, out_ready,
        input  req_ready, core_a, core_b, out_valid, out_id, out_p, out_err, busy
    );

endinterface

// File: rtl/err_recovery_sched_arb.sv
// Round-robin arbiter: first set request at or above ptr, wrapping past NREQ-1.
// Combinational, zero latency.
// No backpressure; the caller decides when a grant is consumed.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IDW'((int'(ptr) + off) % NREQ);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/err_recovery_sched.sv
// Shares one approximate multiplier core among NREQ requesters with optional error recovery.
// Accept -> result valid after CORE_CYCLES+1 cycles; one op in flight, min period CORE_CYCLES+2.
// Requests stall while busy; a result is held stable until out_ready.
module err_recovery_sched
    import err_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int CORE_CYCLES = 3,
    parameter int IDW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    err_recovery_sched_if.slave  bus
);

    localparam int             CW       = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(CORE_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    ptr_nxt;
    logic [IDW-1:0]    id_q;
    logic [CW-1:0]     cnt;
    op_t               op_q;
    op_t               op_in;
    logic              accept;
    logic              capture;
    logic [PROD_W-1:0] out_p_q;
    logic [IDW-1:0]    out_id_q;
    logic              out_err_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        op_in.a       = bus.req_a[int'(gnt_idx) * OP_W +: OP_W];
        op_in.b       = bus.req_b[int'(gnt_idx) * OP_W +: OP_W];
        op_in.recover = bus.req_recover[gnt_idx];
        ptr_nxt       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        capture       = 1'b0;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                // ready is gated by rst so nothing is accepted during a reset cycle
                if (!rst) begin
                    bus.req_ready = gnt;
                    if (|gnt) begin
                        accept    = 1'b1;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            op_q      <= '0;
            id_q      <= '0;
            out_p_q   <= '0;
            out_id_q  <= '0;
            out_err_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_in;
                id_q <= gnt_idx;
                ptr  <= ptr_nxt;
                cnt  <= CNT_INIT;
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                out_p_q   <= op_q.recover ? recover_p(bus.core_p, bus.core_erp) : bus.core_p;
                out_err_q <= |bus.core_erp;
                out_id_q  <= id_q;
            end
        end
    end

    // Operands come straight from registers so the core inputs are quiet for the whole window.
    assign bus.core_a    = op_q.a;
    assign bus.core_b    = op_q.b;
    assign bus.out_valid = (state == DONE);
    assign bus.out_p     = out_p_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = (state != IDLE);

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
    a_ops_stable:   assert property (@(posedge clk) disable iff (rst)
                                     (state == EXEC && $past(state) == EXEC) |-> $stable(op_q));
    a_out_hold:     assert property (@(posedge clk) disable iff (rst)
                                     (bus.out_valid && !bus.out_ready) |=>
                                     (bus.out_valid && $stable(out_p_q) && $stable(out_id_q)));

endmodule

// File: tb/tb_err_recovery_sched.sv
// Bench for err_recovery_sched: core stub, round-robin reference and result scoreboard.
module tb_err_recovery_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        stub_fixed;
    logic [31:0] stub_p;
    logic [11:0] stub_erp;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          model_ptr = 0;
    int          accept_cyc = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] p;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    err_recovery_sched_if #(.NREQ(4)) bus();

    err_recovery_sched #(
        .NREQ        (4),
        .CORE_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Core stub: either a fixed product/error pair or the exact product with no error.
    always_comb begin
        bus.core_p   = stub_fixed ? stub_p : ({16'h0, bus.core_a} * {16'h0, bus.core_b});
        bus.core_erp = stub_fixed ? stub_erp : 12'h000;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: pick the grant from our own pointer and queue the expected result.
    initial forever begin
        int          g;
        logic [31:0] pv;
        logic [31:0] av;
        logic [31:0] bv;
        logic [11:0] ev;
        exp_t        e;
        @(negedge clk);
        if (rst === 1'b1) begin
            exp_q.delete();
            model_ptr = 0;
        end else if ((bus.req_valid & bus.req_ready) != 4'b0000) begin
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && bus.req_valid[(model_ptr + k) % 4]) g = (model_ptr + k) % 4;
            if (g < 0) g = 0;
            av = {16'h0, bus.req_a[16*g +: 16]};
            bv = {16'h0, bus.req_b[16*g +: 16]};
            pv = stub_fixed ? stub_p : av * bv;
            ev = stub_fixed ? stub_erp : 12'h000;
            e.p = pv;
            // erp bit j sits at 2^(20+j) and is re-added at 2^(21+j); bit 11 would land at 2^32
            if (bus.req_recover[g])
                for (int j = 0; j < 11; j++)
                    if (ev[j]) e.p = e.p + (32'd1 << (21 + j));
            e.id  = 2'(g);
            e.err = |ev;
            exp_q.push_back(e);
            model_ptr  = (g + 1) % 4;
            accept_cyc = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_ready(input int r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready[r] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (exp_q.size() != 0);
        e  = ok ? exp_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a = 64'h1111_2222_3333_4444;
        bus.req_b = 64'h5555_6666_7777_8888;
        bus.req_recover = 4'h0;
        bus.out_ready = 1'b0;
        stub_fixed = 1'b0;
        stub_p = 32'h0;
        stub_erp = 12'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.core_a, bus.core_b} !== 32'h0) begin failures++; $display("FAIL reset_core_ops got=%h exp=0", {bus.core_a, bus.core_b}); end
        checks++; if ({bus.out_p, bus.out_id, bus.out_err} !== 35'h0) begin failures++; $display("FAIL reset_outputs got=%h/%h/%b exp=0", bus.out_p, bus.out_id, bus.out_err); end
        drive_edge();
        rst = 1'b0;
        bus.req_valid = 4'h0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin failures++; $display("FAIL idle_after_reset busy=%b ready=%b exp 0/0000", bus.busy, bus.req_ready); end
    endtask

    task automatic test_single_op();
        bit   ok;
        exp_t e;
        drive_edge();
        stub_fixed = 1'b1;
        stub_p = 32'h0001_2340;
        stub_erp = 12'h000;
        bus.req_a[15:0] = 16'h1234;
        bus.req_b[15:0] = 16'h0010;
        bus.req_recover[0] = 1'b0;
        bus.req_valid = 4'b0001;
        wait_ready(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=req_ready[0]"); end
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
        drive_edge();
        bus.req_valid = 4'h0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.core_a !== 16'h1234 || bus.core_b !== 16'h0010 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL exec_window cycle=%0d got a=%h b=%h busy=%b ov=%b exp 1234/0010/1/0", k, bus.core_a, bus.core_b, bus.busy, bus.out_valid);
            end
        end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        checks++; if (cyc - accept_cyc != 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", cyc - accept_cyc); end
        pop_exp(e, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_scoreboard got=empty exp=entry"); end
        checks++; if (bus.out_p !== 32'h0001_2340 || bus.out_p !== e.p) begin failures++; $display("FAIL single_p got=%h exp=00012340", bus.out_p); end
        checks++; if (bus.out_id !== 2'd0 || bus.out_err !== 1'b0) begin failures++; $display("FAIL single_id_err got=%0d/%b exp=0/0", bus.out_id, bus.out_err); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_release busy=%b ov=%b exp 0/0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_recovery();
        logic [31:0] tp   [3] = '{32'h0001_0000, 32'h0001_0000, 32'hFFE0_0000};
        logic [11:0] terp [3] = '{12'h001, 12'h800, 12'h001};
        logic [31:0] texp [3] = '{32'h0021_0000, 32'h0001_0000, 32'h0000_0000};
        bit   ok;
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            int r = c + 1;
            drive_edge();
            stub_fixed = 1'b1;
            stub_p = tp[c];
            stub_erp = terp[c];
            bus.req_a[16*r +: 16] = 16'(c + 7);
            bus.req_b[16*r +: 16] = 16'(c + 9);
            bus.req_recover[r] = 1'b1;
            bus.req_valid = 4'b0001 << r;
            wait_ready(r, ok);
            drive_edge();
            bus.req_valid = 4'h0;
            wait_valid(ok);
            checks++; if (!ok) begin failures++; $display("FAIL recover_valid case=%0d got=timeout exp=out_valid", c); end
            pop_exp(e, ok);
            checks++; if (bus.out_p !== texp[c] || bus.out_p !== e.p) begin failures++; $display("FAIL recover_p case=%0d got=%h exp=%h", c, bus.out_p, texp[c]); end
            checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL recover_err case=%0d got=%b exp=1", c, bus.out_err); end
            checks++; if (bus.out_id !== 2'(r)) begin failures++; $display("FAIL recover_id case=%0d got=%0d exp=%0d", c, bus.out_id, r); end
        end
        drive_edge();
    endtask

    task automatic test_round_robin();
        int   order [5] = '{0, 1, 2, 3, 0};
        int   prev = 0;
        bit   ok;
        exp_t e;
        stub_fixed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[16*i +: 16] = 16'(16'h0100 * (i + 1) + i);
            bus.req_b[16*i +: 16] = 16'(i + 3);
        end
        bus.req_recover = 4'h0;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_valid(ok);
            checks++; if (!ok) begin failures++; $display("FAIL rr_valid op=%0d got=timeout exp=out_valid", k); end
            pop_exp(e, ok);
            checks++; if (bus.out_id !== 2'(order[k]) || bus.out_id !== e.id) begin failures++; $display("FAIL rr_order op=%0d got=%0d exp=%0d", k, bus.out_id, order[k]); end
            checks++; if (bus.out_p !== e.p) begin failures++; $display("FAIL rr_p op=%0d got=%h exp=%h", k, bus.out_p, e.p); end
            checks++; if (cyc - accept_cyc != 4) begin failures++; $display("FAIL rr_latency op=%0d got=%0d exp=4", k, cyc - accept_cyc); end
            if (k > 0) begin
                checks++; if (accept_cyc - prev != 5) begin failures++; $display("FAIL rr_period op=%0d got=%0d exp=5", k, accept_cyc - prev); end
            end
            prev = accept_cyc;
        end
        drive_edge();
        bus.req_valid = 4'b0100;
        wait_ready(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rr_lone_accept got=timeout exp=req_ready[2]"); end
        drive_edge();
        bus.req_valid = 4'h0;
        wait_valid(ok);
        pop_exp(e, ok);
        checks++; if (bus.out_id !== 2'd2) begin failures++; $display("FAIL rr_lone_id got=%0d exp=2", bus.out_id); end
        drive_edge();
        bus.req_valid = 4'hF;
        wait_valid(ok);
        pop_exp(e, ok);
        checks++; if (bus.out_id !== 2'd3 || bus.out_p !== e.p) begin failures++; $display("FAIL rr_after_lone got id=%0d p=%h exp id=3 p=%h", bus.out_id, bus.out_p, e.p); end
        drive_edge();
        bus.req_valid = 4'h0;
    endtask

    task automatic test_backpressure();
        bit   ok;
        exp_t e;
        stub_fixed = 1'b1;
        stub_p = 32'hDEAD_BEEF;
        stub_erp = 12'h0A5;
        bus.out_ready = 1'b0;
        bus.req_a[15:0] = 16'hABCD;
        bus.req_b[15:0] = 16'h0003;
        bus.req_recover[0] = 1'b1;
        bus.req_a[31:16] = 16'h0042;
        bus.req_b[31:16] = 16'h0002;
        bus.req_recover[1] = 1'b0;
        bus.req_valid = 4'b0011;
        wait_ready(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_accept got=timeout exp=req_ready[0]"); end
        drive_edge();
        bus.req_valid = 4'b0010;
        wait_valid(ok);
        stub_p = 32'h0BAD_F00D;
        stub_erp = 12'h000;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_p !== 32'hF34D_BEEF || bus.out_id !== 2'd0 || bus.out_err !== 1'b1 || bus.req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got ov=%b p=%h id=%0d err=%b rdy=%b exp 1/f34dbeef/0/1/0000", i, bus.out_valid, bus.out_p, bus.out_id, bus.out_err, bus.req_ready);
            end
        end
        drive_edge();
        bus.out_ready = 1'b1;
        pop_exp(e, ok);
        checks++; if (bus.out_p !== e.p) begin failures++; $display("FAIL bp_release_p got=%h exp=%h", bus.out_p, e.p); end
        wait_ready(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_stalled_req got=timeout exp=req_ready[1]"); end
        drive_edge();
        bus.req_valid = 4'h0;
        wait_valid(ok);
        pop_exp(e, ok);
        checks++; if (bus.out_id !== 2'd1 || bus.out_p !== 32'h0BAD_F00D || bus.out_p !== e.p) begin failures++; $display("FAIL bp_next got id=%0d p=%h exp id=1 p=0badf00d", bus.out_id, bus.out_p); end
        drive_edge();
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   seen = 0;
        exp_t e;
        stub_fixed = 1'b0;
        bus.req_a[31:16] = 16'h0077;
        bus.req_b[31:16] = 16'h0005;
        bus.req_valid = 4'b0010;
        wait_ready(1, ok);
        drive_edge();
        bus.req_valid = 4'h0;
        @(negedge clk);
        drive_edge();
        rst = 1'b1;
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_output got=%0d valid cycles exp=0", seen); end
        drive_edge();
        bus.req_valid = 4'hF;
        wait_valid(ok);
        pop_exp(e, ok);
        checks++; if (!ok || bus.out_id !== 2'd0 || bus.out_p !== e.p) begin failures++; $display("FAIL midrst_first_grant got id=%0d p=%h exp id=0 p=%h", bus.out_id, bus.out_p, e.p); end
        drive_edge();
        bus.req_valid = 4'h0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_recovery();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
